// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master among NREQ requesters with a CS-high gap.
// Define SPI_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles (rd_data all-ones, err pulse).
module spi_arbiter #(
  parameter int NREQ          = 4,
  parameter int TO_SPI_BITS   = 8,
  parameter int FROM_SPI_BITS = 8,
  parameter int LEN_W         = $clog2(TO_SPI_BITS + FROM_SPI_BITS),
  parameter int GAP           = 100,
  parameter int TIMEOUT       = 4095
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*TO_SPI_BITS-1:0] req_data,
  input  logic [NREQ*LEN_W-1:0]      req_len,
  output logic [NREQ-1:0]            ack,
  output logic [FROM_SPI_BITS-1:0]   rd_data,
  output logic                       err,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       spi_stb_wr,
  output logic [TO_SPI_BITS-1:0]     spi_to_data,
  output logic [LEN_W-1:0]           spi_total_len,
  input  logic                       spi_stb_rdy,
  input  logic [FROM_SPI_BITS-1:0]   spi_from_data
);
  localparam int OW = $clog2(NREQ);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3, S_GAP = 3'd4;
  localparam logic [NREQ-1:0] ONE = 1;
  logic [2:0] state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, last_q, last_d, pick, idx;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [FROM_SPI_BITS-1:0] rd_q, rd_d;
  logic stb_q, stb_d, busy_q, busy_d, grant;
  logic [TO_SPI_BITS-1:0] to_q, to_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GW-1:0] gap_q, gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  // Later overwrites win, so the nearest requester after last takes priority.
  always_comb begin
    pick = last_q;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = OW'((int'(last_q) + i) % NREQ);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    ack_d = '0;
    rd_d = rd_q;
    stb_d = 1'b0;
    to_d = to_q;
    len_d = len_q;
    gap_d = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
    tcnt_d = tcnt_q;
    err_d = 1'b0;
`endif
    case (state_q)
      S_ISSUE: begin
        state_d = (len_q == '0) ? S_DONE : S_WAIT;
        ack_d = (len_q == '0) ? ONE << owner_q : '0;
        rd_d = (len_q == '0) ? '0 : rd_q;
`ifdef SPI_ARB_TIMEOUT_EN
        tcnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (spi_stb_rdy) begin
          state_d = S_DONE;
          ack_d = ONE << owner_q;
          rd_d = spi_from_data;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          ack_d = ONE << owner_q;
          rd_d = '1;
          err_d = 1'b1;
        end else tcnt_d = tcnt_q + 1'b1;
`endif
      end
      S_DONE: begin
        last_d = owner_q;
        state_d = S_GAP;
        gap_d = GW'(GAP - 1);
      end
      S_GAP: begin
        gap_d = (gap_q == '0) ? gap_q : gap_q - 1'b1;
        state_d = (gap_q == '0) ? S_IDLE : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
    // Final gap cycle doubles as an idle cycle so the next strobe lands at ack+GAP+1.
    grant = (state_q == S_IDLE) || (state_q == S_GAP && gap_q == '0);
    if (grant && |req) begin
      state_d = S_ISSUE;
      owner_d = pick;
      to_d = req_data[pick*TO_SPI_BITS +: TO_SPI_BITS];
      len_d = req_len[pick*LEN_W +: LEN_W];
      stb_d = |req_len[pick*LEN_W +: LEN_W];
    end
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q <= OW'(NREQ - 1);
      ack_q <= '0;
      rd_q <= '0;
      stb_q <= 1'b0;
      to_q <= '0;
      len_q <= '0;
      gap_q <= '0;
      busy_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tcnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      ack_q <= ack_d;
      rd_q <= rd_d;
      stb_q <= stb_d;
      to_q <= to_d;
      len_q <= len_d;
      gap_q <= gap_d;
      busy_q <= busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tcnt_q <= tcnt_d;
      err_q <= err_d;
`endif
    end
  end
  assign ack = ack_q;
  assign rd_data = rd_q;
  assign busy = busy_q;
  assign owner = owner_q;
  assign spi_stb_wr = stb_q;
  assign spi_to_data = to_q;
  assign spi_total_len = len_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed checks of grant order, timing, zero-length, drop, reset and timeout.
module tb_spi_arbiter;
  localparam int GAP = 10;
  localparam int LEN_W = 5;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [4*LEN_W-1:0] req_len = '0;
  logic [3:0] ack;
  logic [7:0] rd_data, spi_to_data, spi_from_data = '0;
  logic err, busy, spi_stb_wr, spi_stb_rdy = 1'b0;
  logic [1:0] owner;
  logic [LEN_W-1:0] spi_total_len;
  int vectors = 0, miscompares = 0, cyc = 0;
  spi_arbiter #(.NREQ(4), .TO_SPI_BITS(8), .FROM_SPI_BITS(8), .LEN_W(LEN_W), .GAP(GAP), .TIMEOUT(20)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_len(req_len),
    .ack(ack), .rd_data(rd_data), .err(err), .busy(busy), .owner(owner),
    .spi_stb_wr(spi_stb_wr), .spi_to_data(spi_to_data), .spi_total_len(spi_total_len),
    .spi_stb_rdy(spi_stb_rdy), .spi_from_data(spi_from_data));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask
  task automatic wait_idle();
    for (int w = 0; w < 40 && busy; w++) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_wait busy=%b expected 0", busy); end
  endtask
  task automatic test_reset();
    do_reset();
    vectors++;
    if ({ack, err, busy, owner, rd_data, spi_stb_wr, spi_to_data, spi_total_len} !== '0) begin
      miscompares++;
      $display("FAIL reset_vals ack=%b err=%b busy=%b owner=%0d rd=%h stb=%b to=%h len=%0d expected all 0",
               ack, err, busy, owner, rd_data, spi_stb_wr, spi_to_data, spi_total_len);
    end
  endtask
  task automatic test_single();
    req_data[16 +: 8] = 8'hA5;
    req_len[2*LEN_W +: LEN_W] = 5'd16;
    req = 4'b0100;
    tick();
    vectors++;
    if ({spi_stb_wr, busy, owner, spi_to_data, spi_total_len} !== {1'b1, 1'b1, 2'd2, 8'hA5, 5'd16}) begin
      miscompares++;
      $display("FAIL single_issue stb=%b busy=%b owner=%0d to=%h len=%0d expected 1 1 2 a5 16",
               spi_stb_wr, busy, owner, spi_to_data, spi_total_len);
    end
    tick();
    vectors++;
    if (spi_stb_wr !== 1'b0) begin miscompares++; $display("FAIL single_stb_once stb=%b expected 0", spi_stb_wr); end
    tick();
    spi_stb_rdy = 1'b1;
    spi_from_data = 8'h3C;
    tick();
    spi_stb_rdy = 1'b0;
    req = 4'b0000;
    vectors++;
    if ({ack, rd_data, err, owner, spi_to_data, spi_total_len} !== {4'b0100, 8'h3C, 1'b0, 2'd2, 8'hA5, 5'd16}) begin
      miscompares++;
      $display("FAIL single_ack ack=%b rd=%h err=%b owner=%0d to=%h len=%0d expected 0100 3c 0 2 a5 16",
               ack, rd_data, err, owner, spi_to_data, spi_total_len);
    end
    tick();
    vectors++;
    if ({ack, rd_data} !== {4'b0000, 8'h3C}) begin
      miscompares++;
      $display("FAIL single_hold ack=%b rd=%h expected 0000 3c", ack, rd_data);
    end
    wait_idle();
  endtask
  task automatic test_zero_len();
    req_len[LEN_W +: LEN_W] = '0;
    req_data[8 +: 8] = 8'h77;
    req = 4'b0010;
    tick();
    vectors++;
    if ({spi_stb_wr, busy, owner, ack} !== {1'b0, 1'b1, 2'd1, 4'b0000}) begin
      miscompares++;
      $display("FAIL zero_issue stb=%b busy=%b owner=%0d ack=%b expected 0 1 1 0000", spi_stb_wr, busy, owner, ack);
    end
    tick();
    req = 4'b0000;
    vectors++;
    if ({ack, rd_data, spi_stb_wr} !== {4'b0010, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL zero_ack ack=%b rd=%h stb=%b expected 0010 00 0", ack, rd_data, spi_stb_wr);
    end
    wait_idle();
  endtask
  task automatic test_req_drop();
    int acks = 0, stbs = 0;
    req_data[0 +: 8] = 8'h5A;
    req_len[0 +: LEN_W] = 5'd8;
    req = 4'b0001;
    tick();
    vectors++;
    if ({spi_stb_wr, owner} !== {1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL drop_issue stb=%b owner=%0d expected 1 0", spi_stb_wr, owner);
    end
    req = 4'b0000;
    tick();
    tick();
    spi_stb_rdy = 1'b1;
    spi_from_data = 8'h81;
    tick();
    spi_stb_rdy = 1'b0;
    vectors++;
    if ({ack, rd_data} !== {4'b0001, 8'h81}) begin
      miscompares++;
      $display("FAIL drop_ack ack=%b rd=%h expected 0001 81", ack, rd_data);
    end
    for (int c = 0; c < GAP + 6; c++) begin
      tick();
      acks += int'(ack != 0);
      stbs += int'(spi_stb_wr);
    end
    vectors++;
    if (acks + stbs != 0) begin
      miscompares++;
      $display("FAIL drop_no_regrant acks=%0d stbs=%0d expected 0 0", acks, stbs);
    end
  endtask
  task automatic test_reset_mid();
    req_data[24 +: 8] = 8'hE7;
    req_len[3*LEN_W +: LEN_W] = 5'd12;
    req = 4'b1000;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({ack, err, busy, owner, rd_data, spi_stb_wr, spi_to_data, spi_total_len} !== '0) begin
      miscompares++;
      $display("FAIL midreset_vals ack=%b busy=%b owner=%0d rd=%h stb=%b to=%h len=%0d expected all 0",
               ack, busy, owner, rd_data, spi_stb_wr, spi_to_data, spi_total_len);
    end
    req = 4'b0000;
    tick();
    reset_n = 1'b1;
    tick();
    spi_stb_rdy = 1'b1;
    spi_from_data = 8'h99;
    tick();
    spi_stb_rdy = 1'b0;
    vectors++;
    if ({ack, busy, rd_data} !== {4'b0000, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL midreset_late_rdy ack=%b busy=%b rd=%h expected 0000 0 00", ack, busy, rd_data);
    end
    req = 4'b1000;
    tick();
    vectors++;
    if ({spi_stb_wr, owner, spi_to_data, spi_total_len} !== {1'b1, 2'd3, 8'hE7, 5'd12}) begin
      miscompares++;
      $display("FAIL midreset_regrant stb=%b owner=%0d to=%h len=%0d expected 1 3 e7 12",
               spi_stb_wr, owner, spi_to_data, spi_total_len);
    end
    tick();
    spi_stb_rdy = 1'b1;
    spi_from_data = 8'h42;
    tick();
    spi_stb_rdy = 1'b0;
    req = 4'b0000;
    vectors++;
    if ({ack, rd_data} !== {4'b1000, 8'h42}) begin
      miscompares++;
      $display("FAIL midreset_ack ack=%b rd=%h expected 1000 42", ack, rd_data);
    end
    wait_idle();
  endtask
  task automatic test_fairness();
    int ack_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = 8'hC0 + 8'(i);
      req_len[i*LEN_W +: LEN_W] = 5'd8;
    end
    req = 4'b1111;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 40 && !spi_stb_wr; w++) tick();
      vectors++;
      if ({spi_stb_wr, owner, spi_to_data} !== {1'b1, 2'(k % 4), 8'hC0 + 8'(k % 4)}) begin
        miscompares++;
        $display("FAIL rr_grant%0d stb=%b owner=%0d to=%h expected 1 %0d %h", k, spi_stb_wr, owner,
                 spi_to_data, k % 4, 8'hC0 + 8'(k % 4));
      end
      if (k > 0) begin
        vectors++;
        if (cyc - ack_cyc != GAP + 1) begin
          miscompares++;
          $display("FAIL rr_gap%0d got %0d cycles expected %0d", k, cyc - ack_cyc, GAP + 1);
        end
      end
      tick();
      tick();
      spi_stb_rdy = 1'b1;
      spi_from_data = 8'h10 + 8'(k);
      tick();
      spi_stb_rdy = 1'b0;
      ack_cyc = cyc;
      vectors++;
      if ({ack, rd_data} !== {4'b0001 << (k % 4), 8'h10 + 8'(k)}) begin
        miscompares++;
        $display("FAIL rr_ack%0d ack=%b rd=%h expected %b %h", k, ack, rd_data, 4'b0001 << (k % 4), 8'h10 + 8'(k));
      end
    end
    req = 4'b0000;
    wait_idle();
  endtask
`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    do_reset();
    req_len[0 +: LEN_W] = 5'd8;
    req = 4'b0001;
    tick();
    vectors++;
    if (spi_stb_wr !== 1'b1) begin miscompares++; $display("FAIL to_issue stb=%b expected 1", spi_stb_wr); end
    for (int c = 0; c < 20; c++) begin
      tick();
      early += int'(ack != 0);
    end
    vectors++;
    if (early != 0) begin miscompares++; $display("FAIL to_early acks=%0d expected 0", early); end
    tick();
    req = 4'b0000;
    vectors++;
    if ({ack, err, rd_data} !== {4'b0001, 1'b1, 8'hFF}) begin
      miscompares++;
      $display("FAIL to_ack ack=%b err=%b rd=%h expected 0001 1 ff", ack, err, rd_data);
    end
    tick();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL to_err_pulse err=%b expected 0", err); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_req_drop();
    test_reset_mid();
    test_fairness();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
